// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module : program_sequencer
// Brief  : Replays a loaded 9-bit program onto the processor din bus in step
//          with its one-hot tick FSM; MOV_I consumes an extra immediate word.
// Rev    : 1.0
// ============================================================================
module program_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [8:0]    load_data,
    input  logic          run,
    input  logic          loop_en,
    input  logic [3:0]    tick,
    output logic [8:0]    din,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          halted,
    output logic          load_full,
    output logic          load_ovf
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_run  = 2'd2;
    localparam logic [1:0] c_halt = 2'd3;

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_prog_len;
    logic [8:0]    r_din;
    logic          r_ovf;

    logic          w_advance;
    logic [AW:0]   w_pc_inc;
    logic          w_in_range;
    logic          w_write;

    // Only exact one-hot tick values can trigger an advance.
    assign w_advance  = ((tick == 4'b0001) && (r_din[8:6] == 3'b111)) ||
                        (tick == 4'b1000);
    assign w_pc_inc   = {1'b0, r_pc} + {{AW{1'b0}}, 1'b1};
    assign w_in_range = (w_pc_inc < r_prog_len);
    assign w_write    = (r_state == c_load) && load_valid && (r_wr_ptr < c_depth);

    always_ff @(posedge clk) begin
        if (w_write) begin
            mem[r_wr_ptr[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (load_en) begin
                    w_next = c_load;
                end else if (run) begin
                    w_next = (r_prog_len == '0) ? c_halt : c_run;
                end
            end
            c_load: begin
                if (!load_en) begin
                    w_next = c_idle;
                end
            end
            c_run: begin
                if (!run) begin
                    w_next = c_idle;
                end else if (w_advance && !w_in_range && !loop_en) begin
                    w_next = c_halt;
                end
            end
            default: begin
                if (!run) begin
                    w_next = c_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_din      <= 9'h000;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (load_en) begin
                        r_wr_ptr <= '0;
                        r_ovf    <= 1'b0;
                    end else if (run) begin
                        r_pc  <= '0;
                        r_din <= (r_prog_len == '0) ? 9'h000 : mem[0];
                    end
                end
                c_load: begin
                    if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
                    end else if (load_valid) begin
                        r_ovf <= 1'b1;
                    end
                    if (!load_en) begin
                        r_prog_len <= r_wr_ptr + {{AW{1'b0}}, w_write};
                    end
                end
                c_run: begin
                    if (!run) begin
                        r_pc  <= '0;
                        r_din <= 9'h000;
                    end else if (w_advance) begin
                        if (w_in_range) begin
                            r_pc  <= w_pc_inc[AW-1:0];
                            r_din <= mem[w_pc_inc[AW-1:0]];
                        end else if (loop_en) begin
                            r_pc  <= '0;
                            r_din <= mem[0];
                        end else begin
                            r_din <= 9'h000;
                        end
                    end
                end
                default: begin
                    r_din <= 9'h000;
                end
            endcase
        end
    end

    always_comb begin
        din       = r_din;
        pc        = r_pc;
        prog_len  = r_prog_len;
        halted    = (r_state == c_halt);
        load_ovf  = r_ovf;
        load_full = (r_state == c_load) ? (r_wr_ptr == c_depth)
                                        : (r_prog_len == c_depth);
    end

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_program_sequencer
// Brief  : Randomized bench for program_sequencer against an instruction-walk
//          reference model of the expected din/pc/halted stream.
// Rev    : 1.0
// ============================================================================
module tb_program_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en, load_valid, run, loop_en;
    logic [8:0]    load_data;
    logic [3:0]    tick;
    logic [8:0]    din;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic          halted, load_full, load_ovf;

    program_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid),
        .load_data(load_data), .run(run), .loop_en(loop_en), .tick(tick),
        .din(din), .pc(pc), .prog_len(prog_len), .halted(halted),
        .load_full(load_full), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [8:0] word;
        int         addr;
        bit         hlt;
    } exp_t;

    logic [8:0] ld_buf  [DEPTH+4];
    logic [8:0] ref_mem [DEPTH];
    int         ref_len;
    exp_t       eq[$];

    function automatic int next_addr(input int a, input bit loop);
        if (a + 1 < ref_len) return a + 1;
        if (loop) return 0;
        return -1;
    endfunction

    // Expected per-cycle stream, one processor instruction (4 ticks) at a time.
    task automatic build_expect(input bit loop, input int ncyc);
        int   a;
        int   b;
        int   nxt;
        int   hp;
        exp_t e;
        eq.delete();
        a = 0;
        while (eq.size() < ncyc) begin
            e.word = ref_mem[a]; e.addr = a; e.hlt = 1'b0;
            eq.push_back(e);
            if (ref_mem[a][8:6] == 3'b111) begin
                b = next_addr(a, loop);
                if (b < 0) begin
                    nxt = -1; hp = a;
                end else begin
                    e.word = ref_mem[b]; e.addr = b;
                    repeat (3) eq.push_back(e);
                    nxt = next_addr(b, loop); hp = b;
                end
            end else begin
                repeat (3) eq.push_back(e);
                nxt = next_addr(a, loop); hp = a;
            end
            if (nxt < 0) begin
                e.word = 9'h000; e.addr = hp; e.hlt = 1'b1;
                while (eq.size() < ncyc) eq.push_back(e);
            end else begin
                a = nxt;
            end
        end
    endtask

    task automatic load_words(input int n, input bit merge);
        load_en = 1'b1; load_valid = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = ld_buf[i];
            if (merge && i == n - 1) load_en = 1'b0;
            step();
        end
        load_valid = 1'b0;
        if (!merge || n == 0) begin
            load_en = 1'b0;
            step();
        end
        ref_len = (n < DEPTH) ? n : DEPTH;
        for (int i = 0; i < ref_len; i++) ref_mem[i] = ld_buf[i];
    endtask

    task automatic run_check(input string tag, input bit loop, input int ncyc);
        build_expect(loop, ncyc);
        loop_en = loop; run = 1'b1; tick = 4'b1000;
        step();
        for (int c = 0; c < ncyc; c++) begin
            tick = 4'b0001 << (c % 4);
            check_val({tag, ".din"},    32'(din),    32'(eq[c].word));
            check_val({tag, ".pc"},     32'(pc),     32'(eq[c].addr));
            check_val({tag, ".halted"}, 32'(halted), 32'(eq[c].hlt));
            step();
        end
        run = 1'b0; tick = 4'b0000;
        step();
        check_val({tag, ".idle_din"},    32'(din),    32'h0);
        check_val({tag, ".idle_halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
        run = 1'b0; loop_en = 1'b0; tick = 4'b0000;
        step(); step();
        check_val("rst.din",       32'(din),       32'h0);
        check_val("rst.pc",        32'(pc),        32'h0);
        check_val("rst.prog_len",  32'(prog_len),  32'h0);
        check_val("rst.halted",    32'(halted),    32'h0);
        check_val("rst.load_full", 32'(load_full), 32'h0);
        check_val("rst.load_ovf",  32'(load_ovf),  32'h0);
        rst = 1'b1;
        step();

        // Directed three-word program with a MOV_I
        ld_buf[0] = 9'h1C5; ld_buf[1] = 9'h041; ld_buf[2] = 9'h00C;
        load_words(3, 1'b0);
        check_val("ld3.prog_len",  32'(prog_len),  32'd3);
        check_val("ld3.load_full", 32'(load_full), 32'h0);
        check_val("ld3.load_ovf",  32'(load_ovf),  32'h0);
        run_check("halt3", 1'b0, 12);
        run_check("loop3", 1'b1, 16);

        // Overflow: DEPTH+2 writes
        for (int i = 0; i < DEPTH + 2; i++) ld_buf[i] = 9'($urandom);
        load_words(DEPTH + 2, 1'b0);
        check_val("ovf.prog_len",  32'(prog_len),  32'(DEPTH));
        check_val("ovf.load_full", 32'(load_full), 32'h1);
        check_val("ovf.load_ovf",  32'(load_ovf),  32'h1);
        run_check("ovf.run", 1'b1, 4 * 2 * DEPTH + 4);

        // Non-one-hot ticks must not advance
        ld_buf[0] = 9'h005; ld_buf[1] = 9'h0C3;
        load_words(2, 1'b0);
        loop_en = 1'b0; run = 1'b1; tick = 4'b1000;
        step();
        tick = 4'b0000;
        repeat (3) step();
        check_val("tick0.din", 32'(din), 32'h005);
        tick = 4'b1001;
        step();
        check_val("tick9.din", 32'(din), 32'h005);
        tick = 4'b0001;
        step();
        check_val("tick1.din", 32'(din), 32'h005);
        tick = 4'b1000;
        step();
        check_val("tick8.din", 32'(din), 32'h0C3);
        check_val("tick8.pc",  32'(pc),  32'h1);
        run = 1'b0; tick = 4'b0000;
        step();

        // load_valid outside LOAD is ignored
        load_valid = 1'b1; load_data = 9'h1FF;
        step();
        load_valid = 1'b0;
        check_val("idle_lv.prog_len", 32'(prog_len), 32'd2);

        // load_en wins over run in IDLE
        load_en = 1'b1; run = 1'b1;
        step();
        check_val("prio.din",       32'(din),       32'h0);
        check_val("prio.halted",    32'(halted),    32'h0);
        check_val("prio.load_full", 32'(load_full), 32'h0);
        load_valid = 1'b1; load_data = 9'h0AA;
        step();
        load_valid = 1'b0; load_en = 1'b0; run = 1'b0;
        step();
        check_val("prio.prog_len", 32'(prog_len), 32'd1);
        check_val("prio.din2",     32'(din),      32'h0);

        // Reset mid-RUN at tick 0100
        ld_buf[0] = 9'h1C5; ld_buf[1] = 9'h041; ld_buf[2] = 9'h00C;
        load_words(3, 1'b0);
        loop_en = 1'b1; run = 1'b1; tick = 4'b1000;
        step();
        tick = 4'b0001; step();
        tick = 4'b0010; step();
        tick = 4'b0100;
        #2 rst = 1'b0;
        #1;
        check_val("mid.din",      32'(din),      32'h0);
        check_val("mid.pc",       32'(pc),       32'h0);
        check_val("mid.prog_len", 32'(prog_len), 32'h0);
        check_val("mid.halted",   32'(halted),   32'h0);
        run = 1'b0; tick = 4'b0000;
        step();
        rst = 1'b1;
        step();

        // Empty program goes straight to HALT
        run = 1'b1;
        step();
        check_val("empty.halted", 32'(halted), 32'h1);
        check_val("empty.din",    32'(din),    32'h0);
        step();
        check_val("empty.din2",   32'(din),    32'h0);
        run = 1'b0;
        step();
        check_val("empty.idle",   32'(halted), 32'h0);

        load_words(3, 1'b0);
        run_check("restart", 1'b1, 12);

        // Random programs
        for (int it = 0; it < 10; it++) begin
            int n;
            bit merge;
            bit lp;
            n     = $urandom_range(1, DEPTH);
            merge = 1'($urandom);
            lp    = 1'($urandom);
            for (int i = 0; i < n; i++) begin
                ld_buf[i] = 9'($urandom);
                if ($urandom_range(0, 9) < 3) ld_buf[i][8:6] = 3'b111;
            end
            load_words(n, merge);
            check_val("rnd.prog_len", 32'(prog_len), 32'(n));
            run_check("rnd", lp, 8 * n + 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
